circuit_evaluator: RTL
======================

Name: circuit_evaluator

Overview:
- Drives an evolved combinational/LCELL-feedback circuit under test (4-bit input, 1-bit output) through every input vector.
- Samples the response after a settle interval and records a truth table plus per-vector instability flags.
- Acts as the stimulus/capture end of the circuit-test interface: it generates the circuit's inputs and consumes its output.
- Sits between the test controller (start/done) and the circuit under test.

Parameters:
- IN_WIDTH, 4: width of the stimulus bus. Vector count N = 2**IN_WIDTH.
- SETTLE_CYCLES, 8: cycles to wait after applying a vector before sampling. Must be >= 2, to cover synchronizer latency.
- SAMPLES, 4: consecutive samples taken per vector. Must be >= 1.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin a full sweep; accepted only in IDLE.
- dut_in  out  IN_WIDTH  stimulus to the circuit under test; registered.
- dut_out  in  1  circuit output; asynchronous, may oscillate.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at sweep end.
- truth_table  out  N  bit i = captured response to vector i.
- unstable  out  N  bit i = 1 if the samples for vector i disagreed.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; dut_in=0, busy=0, done=0, truth_table=0, unstable=0; synchronizer flops=0; counters=0.
- dut_out passes through a 2-flop synchronizer. Only the synchronized value (sync_out) is used.
- IDLE:
  - start=1 → clear vec index, truth_table, unstable → APPLY. busy=1 from the next cycle.
- APPLY (1 cycle):
  - dut_in <= vec; settle counter <= 0 → SETTLE.
- SETTLE (SETTLE_CYCLES cycles):
  - Count up; at SETTLE_CYCLES-1 → SAMPLE.
- SAMPLE (SAMPLES cycles):
  - First cycle: latch sync_out as ref.
  - Every later cycle: set mismatch flag if sync_out != ref.
  - After the last sample → STORE.
- STORE (1 cycle):
  - truth_table[vec] <= ref; unstable[vec] <= mismatch flag; clear flag.
  - If vec == N-1 → DONE; else vec <= vec+1 → APPLY.
- DONE (1 cycle):
  - done=1, busy=0 → IDLE.
  - dut_in holds its last vector.
  - truth_table and unstable hold until the next accepted start.
- Timing:
  - Per vector: SETTLE_CYCLES+SAMPLES+2 cycles.
  - done asserts N*(SETTLE_CYCLES+SAMPLES+2)+1 cycles after the start-accept edge: 225 with defaults.
- Boundaries:
  - start while busy or in DONE: ignored, no effect on sweep.
  - start held high continuously: a new sweep begins on the cycle after DONE.
  - vec wrap: never increments past N-1.
  - rst_n asserted mid-sweep: immediate return to reset values; partial results discarded; no done pulse.
  - Oscillating output: ref is still recorded in truth_table; unstable flags it.

Optional Feature:
- Macro: CIRCUIT_EVALUATOR_COMPARE_EN.
- Defined: adds input expected [N] and outputs mismatches [IN_WIDTH+1] and pass [1].
  - In STORE: mismatches increments if ref != expected[vec] OR unstable.
  - On DONE: pass = (mismatches == 0). pass is registered and holds until next start.
  - Both clear on reset and on start-accept.
  - expected is sampled per vector, so the bench holds it stable during the sweep.
- Not defined: ports absent; no comparison logic.

Test Plan:
- XOR model, dut_out = in[1]^in[0], start pulse → done at cycle 225, truth_table=16'h6666, unstable=16'h0000.
- Oscillator model, dut_out toggles every clk when dut_in==4'hA, else 0 → unstable=16'h0400, truth_table bits 0..9, 11..15 = 0.
- rst_n low for 1 cycle at cycle 100 of a sweep → all outputs 0 immediately, no done; a new start then gives a full correct sweep.
- start re-pulsed at cycles 50 and 120 during a sweep → single done at 225; results identical to an undisturbed run.
- Timing check with SETTLE_CYCLES=2, SAMPLES=1, constant dut_out=1 → done at 16*5+1=81, truth_table=16'hFFFF.
- With CIRCUIT_EVALUATOR_COMPARE_EN: expected=16'h6666, model dut_out=in[0] → truth_table=16'hAAAA, mismatches=8, pass=0; expected=16'hAAAA → mismatches=0, pass=1.

Source files
------------

// File: rtl/circuit_evaluator.sv
// Sweeps every stimulus vector through an evolved circuit, captures its synchronized
// response as a truth table and flags vectors whose samples disagree.
// Optional golden compare: define CIRCUIT_EVALUATOR_COMPARE_EN.
//
// state  | meaning
// IDLE   | waiting for start
// APPLY  | drive current vector onto dut_in
// SETTLE | let the circuit and synchronizer settle
// SAMPLE | capture reference sample, then watch for disagreement
// STORE  | write truth_table/unstable bit, advance vector
// DONE   | sweep finished, done pulses on the following cycle
module circuit_evaluator #(
  parameter int IN_WIDTH      = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int SAMPLES       = 4,
  localparam int N            = 2**IN_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic [IN_WIDTH-1:0] dut_in,
  input  logic                dut_out,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        truth_table,
`ifdef CIRCUIT_EVALUATOR_COMPARE_EN
  input  logic [N-1:0]        expected,
  output logic [IN_WIDTH:0]   mismatches,
  output logic                pass,
`endif
  output logic [N-1:0]        unstable
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int KW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_APPLY, S_SETTLE, S_SAMPLE, S_STORE, S_DONE
  } state_t;

  state_t              state, state_nxt;
  logic                sync1, sync2;
  logic [IN_WIDTH-1:0] vec;
  logic [SW-1:0]       settle_cnt;
  logic [KW-1:0]       samp_cnt;
  logic                ref_bit;
  logic                mism_flag;
  logic                last_vec;
  logic                settle_end;
  logic                sample_end;

  assign last_vec   = (vec == IN_WIDTH'(N-1));
  assign settle_end = (settle_cnt == SW'(SETTLE_CYCLES-1));
  assign sample_end = (samp_cnt == KW'(SAMPLES-1));

  // dut_out is fully asynchronous and may oscillate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= dut_out;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_APPLY;
      S_APPLY:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_end) state_nxt = S_SAMPLE;
      S_SAMPLE: if (sample_end) state_nxt = S_STORE;
      S_STORE:  state_nxt = last_vec ? S_DONE : S_APPLY;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_in      <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
      unstable    <= '0;
      vec         <= '0;
      settle_cnt  <= '0;
      samp_cnt    <= '0;
      ref_bit     <= 1'b0;
      mism_flag   <= 1'b0;
`ifdef CIRCUIT_EVALUATOR_COMPARE_EN
      mismatches  <= '0;
      pass        <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            vec         <= '0;
            truth_table <= '0;
            unstable    <= '0;
            mism_flag   <= 1'b0;
            busy        <= 1'b1;
`ifdef CIRCUIT_EVALUATOR_COMPARE_EN
            mismatches  <= '0;
            pass        <= 1'b0;
`endif
          end
        end
        S_APPLY: begin
          dut_in     <= vec;
          settle_cnt <= '0;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt + SW'(1);
          samp_cnt   <= '0;
        end
        S_SAMPLE: begin
          samp_cnt <= samp_cnt + KW'(1);
          if (samp_cnt == '0)         ref_bit   <= sync2;
          else if (sync2 != ref_bit) mism_flag <= 1'b1;
        end
        S_STORE: begin
          truth_table[vec] <= ref_bit;
          unstable[vec]    <= mism_flag;
          mism_flag        <= 1'b0;
`ifdef CIRCUIT_EVALUATOR_COMPARE_EN
          if ((ref_bit != expected[vec]) || mism_flag)
            mismatches <= mismatches + (IN_WIDTH+1)'(1);
`endif
          if (!last_vec) vec <= vec + IN_WIDTH'(1);
        end
        S_DONE: begin
          done <= 1'b1;
          busy <= 1'b0;
`ifdef CIRCUIT_EVALUATOR_COMPARE_EN
          pass <= (mismatches == '0);
`endif
        end
        default: ;
      endcase
    end
  end

endmodule
